gpzda_transmitter: RTL

- Serialises one GPZDA time/date sentence as a stream of ASCII bytes over a valid/ready byte handshake.
- The bytes are in the format accepted by the team's GPZDA receiver: `$GPZDA,hhmmss.ss,DD,MM,YYYY,,*CC`, with optional `CR LF` at the end.
- Converts binary day/month/year to zero-padded decimal and appends the uppercase hex XOR checksum.
- Sits between the time-keeping logic and the UART transmit path.

---
 rtl/gpzda_transmitter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/gpzda_transmitter.sv
// gpzda_transmitter: serialises one "$GPZDA,hhmmss.ss,DD,MM,YYYY,,*CC[CR LF]"
// sentence as ASCII bytes over a load/ready byte handshake.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   start                 - one-cycle send request, honoured only when idle
//   utc                   - nine ASCII characters "hhmmss.ss", first char in MSBs
//   day, month, year      - binary date fields, converted to zero-padded decimal
//   ready                 - downstream accepts the byte on data this cycle
//   load, data            - byte valid flag and current byte
//   busy                  - sentence in progress
//   done                  - one-cycle pulse at sentence end or range rejection
//   error                 - last request had an out-of-range field
module gpzda_transmitter #(
  parameter int unsigned             B         = 8,
  parameter int unsigned             PrefixLen = 5,
  parameter logic [PrefixLen*B-1:0]  Prefix    = "GPZDA",
  parameter logic [B-1:0]            Separator = ",",
  parameter bit                      EmitCrLf  = 1'b1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [9*B-1:0] utc,
  input  logic [2*B-1:0] day,
  input  logic [2*B-1:0] month,
  input  logic [2*B-1:0] year,
  input  logic           ready,
  output logic           load,
  output logic [B-1:0]   data,
  output logic           busy,
  output logic           done,
  output logic           error
);

  localparam int unsigned BinW = 2 * B;  // binary field width, also the number of shift steps

  localparam logic [1:0] S_Idle    = 2'd0;
  localparam logic [1:0] S_Convert = 2'd1;
  localparam logic [1:0] S_Send    = 2'd2;
  localparam logic [1:0] S_Done    = 2'd3;

  // Byte positions within the sentence; position 0 is "$".
  localparam int unsigned IdxSep0 = PrefixLen + 1;
  localparam int unsigned IdxUtc  = IdxSep0 + 1;
  localparam int unsigned IdxSep1 = IdxUtc + 9;
  localparam int unsigned IdxDay  = IdxSep1 + 1;
  localparam int unsigned IdxSep2 = IdxDay + 2;
  localparam int unsigned IdxMon  = IdxSep2 + 1;
  localparam int unsigned IdxSep3 = IdxMon + 2;
  localparam int unsigned IdxYear = IdxSep3 + 1;
  localparam int unsigned IdxSep4 = IdxYear + 4;
  localparam int unsigned IdxSep5 = IdxSep4 + 1;
  localparam int unsigned IdxStar = IdxSep5 + 1;
  localparam int unsigned IdxChi  = IdxStar + 1;
  localparam int unsigned IdxClo  = IdxChi + 1;
  localparam int unsigned IdxCr   = IdxClo + 1;
  localparam int unsigned IdxLf   = IdxCr + 1;
  localparam int unsigned IdxLast = EmitCrLf ? IdxLf : IdxClo;

  logic [1:0]      state, state_d;
  logic            load_d, busy_d, done_d, error_d;
  logic [B-1:0]    data_d, chk, chk_d, next_byte;
  logic [5:0]      idx, idx_d, nxt_idx, utc_off;
  logic [9*B-1:0]  utc_q, utc_d;
  logic [BinW-1:0] day_q, day_d, month_q, month_d, year_q, year_d;
  logic [7:0]      bcd_day, bcd_day_d, bcd_mon, bcd_mon_d;
  logic [15:0]     bcd_yr, bcd_yr_d;
  logic [BinW+7:0] day_sh, mon_sh;
  logic [BinW+15:0] yr_sh;

  // Double-dabble digit correction applied before each shift.
  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [B-1:0] dec(input logic [3:0] n);
    return B'(8'h30) + B'(n);
  endfunction

  function automatic logic [B-1:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? B'(8'h30) + B'(n) : B'(8'h37) + B'(n);
  endfunction

  // Byte that follows the one currently on data.
  always_comb begin
    nxt_idx   = idx + 6'd1;
    utc_off   = nxt_idx - 6'(IdxUtc);
    next_byte = Separator;
    if (nxt_idx >= 6'd1 && nxt_idx <= 6'(PrefixLen))
      next_byte = Prefix[B*(PrefixLen - int'(nxt_idx)) +: B];
    else if (nxt_idx >= 6'(IdxUtc) && nxt_idx < 6'(IdxSep1))
      next_byte = utc_q[B*(8 - int'(utc_off)) +: B];
    else if (nxt_idx == 6'(IdxDay))      next_byte = dec(bcd_day[7:4]);
    else if (nxt_idx == 6'(IdxDay + 1))  next_byte = dec(bcd_day[3:0]);
    else if (nxt_idx == 6'(IdxMon))      next_byte = dec(bcd_mon[7:4]);
    else if (nxt_idx == 6'(IdxMon + 1))  next_byte = dec(bcd_mon[3:0]);
    else if (nxt_idx == 6'(IdxYear))     next_byte = dec(bcd_yr[15:12]);
    else if (nxt_idx == 6'(IdxYear + 1)) next_byte = dec(bcd_yr[11:8]);
    else if (nxt_idx == 6'(IdxYear + 2)) next_byte = dec(bcd_yr[7:4]);
    else if (nxt_idx == 6'(IdxYear + 3)) next_byte = dec(bcd_yr[3:0]);
    else if (nxt_idx == 6'(IdxStar))     next_byte = B'(8'h2A);
    else if (nxt_idx == 6'(IdxChi))      next_byte = hex(chk[7:4]);
    else if (nxt_idx == 6'(IdxClo))      next_byte = hex(chk[3:0]);
    else if (nxt_idx == 6'(IdxCr))       next_byte = B'(8'h0D);
    else if (nxt_idx == 6'(IdxLf))       next_byte = B'(8'h0A);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state;
    load_d    = load;
    data_d    = data;
    busy_d    = busy;
    done_d    = 1'b0;
    error_d   = error;
    chk_d     = chk;
    idx_d     = idx;
    utc_d     = utc_q;
    day_d     = day_q;
    month_d   = month_q;
    year_d    = year_q;
    bcd_day_d = bcd_day;
    bcd_mon_d = bcd_mon;
    bcd_yr_d  = bcd_yr;
    day_sh    = {adj(bcd_day[7:4]), adj(bcd_day[3:0]), day_q} << 1;
    mon_sh    = {adj(bcd_mon[7:4]), adj(bcd_mon[3:0]), month_q} << 1;
    yr_sh     = {adj(bcd_yr[15:12]), adj(bcd_yr[11:8]), adj(bcd_yr[7:4]),
                 adj(bcd_yr[3:0]), year_q} << 1;
    case (state)
      S_Idle: begin
        if (start) begin
          utc_d   = utc;
          day_d   = day;
          month_d = month;
          year_d  = year;
          busy_d  = 1'b1;
          error_d = 1'b0;
          chk_d   = '0;
          idx_d   = '0;
          state_d = S_Convert;
        end
      end
      S_Convert: begin
        // idx 0 is the range-check cycle; idx 1..BinW are the shift steps.
        if (idx == 6'd0) begin
          if (day_q > BinW'(99) || month_q > BinW'(99) || year_q > BinW'(9999)) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_Done;
          end else begin
            idx_d     = 6'd1;
            bcd_day_d = '0;
            bcd_mon_d = '0;
            bcd_yr_d  = '0;
          end
        end else begin
          day_d     = day_sh[BinW-1:0];
          bcd_day_d = day_sh[BinW+7:BinW];
          month_d   = mon_sh[BinW-1:0];
          bcd_mon_d = mon_sh[BinW+7:BinW];
          year_d    = yr_sh[BinW-1:0];
          bcd_yr_d  = yr_sh[BinW+15:BinW];
          if (idx == 6'(BinW)) begin
            state_d = S_Send;
            load_d  = 1'b1;
            data_d  = B'(8'h24);
            idx_d   = '0;
          end else begin
            idx_d = idx + 6'd1;
          end
        end
      end
      S_Send: begin
        if (ready) begin
          // Checksum covers bytes strictly between "$" and "*".
          if (idx >= 6'd1 && idx <= 6'(IdxSep5))
            chk_d = chk ^ data;
          if (idx == 6'(IdxLast)) begin
            load_d  = 1'b0;
            data_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_Done;
          end else begin
            data_d = next_byte;
            idx_d  = nxt_idx;
          end
        end
      end
      S_Done:  state_d = S_Idle;
      default: state_d = S_Idle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_Idle;
      load    <= 1'b0;
      data    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      chk     <= '0;
      idx     <= '0;
      utc_q   <= '0;
      day_q   <= '0;
      month_q <= '0;
      year_q  <= '0;
      bcd_day <= '0;
      bcd_mon <= '0;
      bcd_yr  <= '0;
    end else begin
      state   <= state_d;
      load    <= load_d;
      data    <= data_d;
      busy    <= busy_d;
      done    <= done_d;
      error   <= error_d;
      chk     <= chk_d;
      idx     <= idx_d;
      utc_q   <= utc_d;
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      bcd_day <= bcd_day_d;
      bcd_mon <= bcd_mon_d;
      bcd_yr  <= bcd_yr_d;
    end
  end

endmodule
